// File: rtl/counter_n.sv
// -----------------------------------------------------------------------------
// counter_n
//
// Parametrised synchronous counter. Counts through 0..MODULUS-1, either up or
// down, with a count enable, a parallel load (clamped to MODULUS-1), and a
// wrap or saturate end mode. Status outputs give terminal count and a
// one-cycle wrap pulse.
//
// Parameters:
//   WIDTH        bit width of o_count / i_load_value (1..32)
//   MODULUS      number of count states (2..2**WIDTH)
//   RESET_VALUE  value taken on reset (< MODULUS)
//   PRESCALE     only with COUNTER_N_PRESCALE_EN: advance every PRESCALE-th
//                enabled edge (>= 1)
//
// Optional feature macro: COUNTER_N_PRESCALE_EN
//   When defined, adds the PRESCALE parameter and an internal prescaler that
//   is cleared by reset and load, holds while i_enable is low, and gates
//   the count advance.
//
// Ports:
//   i_clk         clock, all state changes on the rising edge
//   i_reset       synchronous active-high reset (highest priority)
//   i_enable      count enable
//   i_up          direction: 1 = increment, 0 = decrement
//   i_saturate    end mode: 1 = saturate at limit, 0 = wrap
//   i_load        parallel load strobe (priority over enable)
//   i_load_value  value to load
//   o_count       current count (registered)
//   o_terminal    combinational: count is at the limit for the current direction
//   o_wrap        registered one-cycle pulse when the count wraps
// -----------------------------------------------------------------------------
module counter_n #(
    parameter int unsigned      WIDTH       = 4,
    parameter longint unsigned  MODULUS     = 16,
    parameter longint unsigned  RESET_VALUE = 0
`ifdef COUNTER_N_PRESCALE_EN
    ,
    parameter int unsigned      PRESCALE    = 4
`endif
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_up,
    input  logic             i_saturate,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] o_count,
    output logic             o_terminal,
    output logic             o_wrap
);

    // Limit held at WIDTH+1 bits so MODULUS = 2**WIDTH is representable
    // without overflow in the comparisons below.
    localparam logic [WIDTH:0]   LIMIT_EXT   = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] LIMIT       = LIMIT_EXT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             wrap_reg;
    logic             wrap_next;

    logic             at_max;
    logic             at_min;
    logic             load_over;
    logic [WIDTH-1:0] load_clamped;
    logic             tick;

    assign at_max    = ({1'b0, count_reg} == LIMIT_EXT);
    assign at_min    = (count_reg == '0);
    assign load_over = ({1'b0, i_load_value} > LIMIT_EXT);
    assign load_clamped = load_over ? LIMIT : i_load_value;

`ifdef COUNTER_N_PRESCALE_EN
    localparam int unsigned      PS_W    = $clog2(PRESCALE) + 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] prescale_reg;
    logic [PS_W-1:0] prescale_next;

    // The tick fires on the enabled edge where the prescaler sits at its
    // last value; that same edge returns the prescaler to 0.
    assign tick = (prescale_reg == PS_LAST);

    always_comb begin
        prescale_next = prescale_reg;
        if (i_load) begin
            prescale_next = '0;
        end else if (i_enable) begin
            if (tick) begin
                prescale_next = '0;
            end else begin
                prescale_next = prescale_reg + PS_W'(1);
            end
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Next-state: load > enable > hold. Reset is applied in the register.
    // The +1 / -1 paths never overflow WIDTH bits because they are only
    // taken when the count is strictly inside 0..MODULUS-1.
    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        if (i_load) begin
            count_next = load_clamped;
        end else if (i_enable && tick) begin
            if (i_up) begin
                if (!at_max) begin
                    count_next = count_reg + WIDTH'(1);
                end else if (!i_saturate) begin
                    count_next = '0;
                    wrap_next  = 1'b1;
                end
            end else begin
                if (!at_min) begin
                    count_next = count_reg - WIDTH'(1);
                end else if (!i_saturate) begin
                    count_next = LIMIT;
                    wrap_next  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_reg    <= RESET_COUNT;
            wrap_reg     <= 1'b0;
`ifdef COUNTER_N_PRESCALE_EN
            prescale_reg <= '0;
`endif
        end else begin
            count_reg    <= count_next;
            wrap_reg     <= wrap_next;
`ifdef COUNTER_N_PRESCALE_EN
            prescale_reg <= prescale_next;
`endif
        end
    end

    assign o_count    = count_reg;
    assign o_wrap     = wrap_reg;
    // Terminal depends only on the live direction and the current count.
    assign o_terminal = i_up ? at_max : at_min;

endmodule

// File: tb/tb_counter_n.sv
// -----------------------------------------------------------------------------
// tb_counter_n
//
// Scoreboard bench for counter_n (WIDTH=4, MODULUS=10, RESET_VALUE=0).
// The stimulus process drives inputs on the falling edge, advances an
// arithmetic reference model and pushes the expected post-edge outputs.
// A monitor samples just after each rising edge and pops/compares.
// -----------------------------------------------------------------------------
module tb_counter_n;

    localparam int W   = 4;
    localparam int M   = 10;
    localparam int RV  = 0;
`ifdef COUNTER_N_PRESCALE_EN
    localparam int PS  = 3;
`else
    localparam int PS  = 1;
`endif

    typedef struct {
        int cnt;
        int wrap;
        int term;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         up;
    logic         saturate;
    logic         load;
    logic [W-1:0] load_value;
    logic [W-1:0] count;
    logic         terminal;
    logic         wrap;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   seq   = 0;

    // Reference model state
    int m_cnt  = 0;
    int m_wrap = 0;
    int m_ps   = 0;

    always #5 clk = ~clk;

    counter_n #(
        .WIDTH       (W),
        .MODULUS     (M),
        .RESET_VALUE (RV)
`ifdef COUNTER_N_PRESCALE_EN
        ,
        .PRESCALE    (PS)
`endif
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_enable     (enable),
        .i_up         (up),
        .i_saturate   (saturate),
        .i_load       (load),
        .i_load_value (load_value),
        .o_count      (count),
        .o_terminal   (terminal),
        .o_wrap       (wrap)
    );

    // One edge of stimulus plus the model's view of what follows it.
    task automatic step(input bit r, input bit ld, input int lv,
                        input bit en, input bit u, input bit sat);
        exp_t e;
        bit   tk;
        @(negedge clk);
        reset      = r;
        load       = ld;
        load_value = W'(lv);
        enable     = en;
        up         = u;
        saturate   = sat;
        if (r) begin
            m_cnt = RV; m_wrap = 0; m_ps = 0;
        end else if (ld) begin
            m_cnt = (lv >= M) ? M - 1 : lv; m_wrap = 0; m_ps = 0;
        end else if (!en) begin
            m_wrap = 0;
        end else begin
            m_ps = (m_ps + 1) % PS;
            tk   = (m_ps == 0);
            m_wrap = 0;
            if (tk) begin
                if (u) begin
                    if (m_cnt < M - 1)  m_cnt = m_cnt + 1;
                    else if (!sat)      begin m_cnt = 0; m_wrap = 1; end
                end else begin
                    if (m_cnt > 0)      m_cnt = m_cnt - 1;
                    else if (!sat)      begin m_cnt = M - 1; m_wrap = 1; end
                end
            end
        end
        e.cnt  = m_cnt;
        e.wrap = m_wrap;
        e.term = u ? int'(m_cnt == M - 1) : int'(m_cnt == 0);
        exp_q.push_back(e);
    endtask

    // Monitor: one transaction per rising edge that has an expectation queued.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total = total + 3;
            if (int'(count) != e.cnt) begin
                bad++;
                $display("FAIL count[%0d]: got %0d want %0d", seq, count, e.cnt);
            end
            if (int'(wrap) != e.wrap) begin
                bad++;
                $display("FAIL wrap[%0d]: got %0d want %0d (count=%0d)", seq, wrap, e.wrap, count);
            end
            if (int'(terminal) != e.term) begin
                bad++;
                $display("FAIL terminal[%0d]: got %0d want %0d (count=%0d up=%0d)", seq, terminal, e.term, count, up);
            end
            $display("txn %0d: rst=%0d ld=%0d lv=%0d en=%0d up=%0d sat=%0d -> count=%0d wrap=%0d term=%0d",
                     seq, reset, load, load_value, enable, up, saturate, count, wrap, terminal);
            seq++;
        end
    end

    initial begin
        reset = 1'b0; load = 1'b0; load_value = '0;
        enable = 1'b0; up = 1'b1; saturate = 1'b0;

        // Reset beats a simultaneous load
        step(1, 1, 7, 0, 1, 0);
        step(1, 1, 7, 0, 1, 0);
        // Wrap up-count from 0 through 9 back to 0..2
        for (int i = 0; i < 12 * PS; i++) step(0, 0, 0, 1, 1, 0);
        // Load 0, count down with wrap
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3 * PS; i++) step(0, 0, 0, 1, 0, 0);
        // Load 8, saturate up, then one wrap
        step(0, 1, 8, 0, 1, 1);
        for (int i = 0; i < 4 * PS; i++) step(0, 0, 0, 1, 1, 1);
        for (int i = 0; i < PS; i++)     step(0, 0, 0, 1, 1, 0);
        // Load clamp ignoring enable, then hold with enable low
        step(0, 1, 13, 1, 1, 0);
        step(0, 1, 5, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
        // Saturate down at 0
        step(0, 1, 0, 0, 0, 1);
        for (int i = 0; i < 2 * PS; i++) step(0, 0, 0, 1, 0, 1);
        // Count to 6, reset beats load and enable, then resume
        step(0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 6 * PS; i++) step(0, 0, 0, 1, 1, 0);
        step(1, 1, 4, 1, 1, 0);
        for (int i = 0; i < 3 * PS; i++) step(0, 0, 0, 1, 1, 0);

        // Randomised phase
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 10,
                 int'($urandom_range(0, 15)),
                 $urandom_range(0, 99) < 75,
                 1'($urandom),
                 $urandom_range(0, 99) < 30);
        end

        // Drain the scoreboard with a bounded wait
        begin
            int budget;
            budget = 20;
            while (exp_q.size() != 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            #2;
            if (exp_q.size() != 0) begin
                total++;
                bad++;
                $display("FAIL drain: got %0d pending want 0", exp_q.size());
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
